// File: rtl/tnn_pkg.sv
// Shared definitions for the ternary neuron back end: activation codes, FSM states and the
// symmetric saturation limit of the signed accumulator.
package tnn_pkg;

  localparam logic [1:0] TNN_POS  = 2'b01;
  localparam logic [1:0] TNN_NEG  = 2'b11;
  localparam logic [1:0] TNN_ZERO = 2'b00;

  typedef enum logic [0:0] {
    ACCUM,
    RESULT
  } tnn_state_e;

  // Largest magnitude the accumulator may hold; the most-negative code is never used.
  function automatic int sat_limit(input int unsigned acc_w);
    return (1 << (acc_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/tnn_ternary_threshold.sv
// Combinational ternary thresholding of a signed sum; +1 wins when the thresholds overlap.
module tnn_ternary_threshold
  import tnn_pkg::*;
#(
  parameter int unsigned ACC_W = 8
) (
  input  logic signed [ACC_W-1:0] sum,
  input  logic signed [ACC_W-1:0] thr_hi,
  input  logic signed [ACC_W-1:0] thr_lo,
  output logic        [1:0]       act
);

  always_comb begin
    act = TNN_ZERO;
    if (sum >= thr_hi) begin
      act = TNN_POS;
    end else if (sum <= thr_lo) begin
      act = TNN_NEG;
    end
  end

endmodule

// File: rtl/tnn_neuron_accum.sv
// Accumulates (pos - neg) popcounts over NUM_CHUNKS beats with saturation, then presents a
// thresholded ternary activation and the final sum on a valid/ready output.
module tnn_neuron_accum
  import tnn_pkg::*;
#(
  parameter int unsigned CNT_W      = 5,
  parameter int unsigned NUM_CHUNKS = 4,
  parameter int unsigned ACC_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic        [CNT_W-1:0] in_pos_cnt,
  input  logic        [CNT_W-1:0] in_neg_cnt,
  input  logic signed [ACC_W-1:0] thr_hi,
  input  logic signed [ACC_W-1:0] thr_lo,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [1:0]       out_act,
  output logic signed [ACC_W-1:0] out_sum
);

  localparam int unsigned IdxW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CHUNKS - 1);
  // Wide enough that acc + pos - neg can never wrap before clamping.
  localparam int unsigned SumW = ACC_W + CNT_W + 2;
  localparam logic signed [SumW-1:0] Lim = SumW'(sat_limit(ACC_W));

  tnn_state_e state_q, state_d;

  logic signed [ACC_W-1:0] acc_q;
  logic        [IdxW-1:0]  chunk_idx_q;
  logic signed [SumW-1:0]  sum_ext;
  logic signed [SumW-1:0]  sum_clamp;
  logic signed [ACC_W-1:0] acc_sat;
  logic        [1:0]       act_next;
  logic                    accept;
  logic                    last_beat;

  assign accept    = in_valid && in_ready;
  assign last_beat = (chunk_idx_q == LastIdx);

  always_comb begin
    sum_ext = SumW'(acc_q) + $signed(SumW'(in_pos_cnt)) - $signed(SumW'(in_neg_cnt));
    sum_clamp = sum_ext;
    if (sum_ext > Lim) begin
      sum_clamp = Lim;
    end else if (sum_ext < -Lim) begin
      sum_clamp = -Lim;
    end
    acc_sat = ACC_W'(sum_clamp);
  end

  tnn_ternary_threshold #(
    .ACC_W(ACC_W)
  ) u_threshold (
    .sum   (acc_sat),
    .thr_hi(thr_hi),
    .thr_lo(thr_lo),
    .act   (act_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && last_beat) state_d = RESULT;
      RESULT:  if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
    if (clr) begin
      state_d = ACCUM;
    end
  end

  always_comb begin
    in_ready  = (state_q == ACCUM) && !clr;
    out_valid = (state_q == RESULT);
  end

  // Datapath; out_act/out_sum are only updated on a last beat, so clr leaves them stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      chunk_idx_q <= '0;
      out_act     <= TNN_ZERO;
      out_sum     <= '0;
    end else if (clr) begin
      acc_q       <= '0;
      chunk_idx_q <= '0;
    end else if (accept) begin
      if (last_beat) begin
        acc_q       <= '0;
        chunk_idx_q <= '0;
        out_sum     <= acc_sat;
        out_act     <= act_next;
      end else begin
        acc_q       <= acc_sat;
        chunk_idx_q <= chunk_idx_q + IdxW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tnn_neuron_accum.sv
// Scoreboard bench: two neurons (ACC_W 8 and 6) share stimulus; a reference model predicts
// results into a queue that an independent monitor checks at each presented output.
module tb_tnn_neuron_accum;

  localparam int NC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] in_pos_cnt = '0;
  logic [4:0] in_neg_cnt = '0;
  logic [7:0] thr_hi = '0;
  logic [7:0] thr_lo = '0;
  logic       out_ready = 1'b0;
  logic [5:0] thr_hi_b, thr_lo_b;

  logic       in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [1:0] out_act_a, out_act_b;
  logic [7:0] out_sum_a;
  logic [5:0] out_sum_b;

  assign thr_hi_b = thr_hi[5:0];
  assign thr_lo_b = thr_lo[5:0];

  always #5 clk = ~clk;

  tnn_neuron_accum #(.CNT_W(5), .NUM_CHUNKS(NC), .ACC_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_pos_cnt(in_pos_cnt), .in_neg_cnt(in_neg_cnt), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_act(out_act_a), .out_sum(out_sum_a)
  );

  tnn_neuron_accum #(.CNT_W(5), .NUM_CHUNKS(NC), .ACC_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_pos_cnt(in_pos_cnt), .in_neg_cnt(in_neg_cnt), .thr_hi(thr_hi_b), .thr_lo(thr_lo_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_act(out_act_b), .out_sum(out_sum_b)
  );

  typedef struct {
    int sum_a;
    int act_a;
    int sum_b;
    int act_b;
  } exp_t;

  exp_t sb[$];
  int   m_pos[$];
  int   m_neg[$];
  bit   m_pending = 1'b0;
  int   cur_hi = 0;
  int   cur_lo = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Beat-by-beat saturating sum of the current neuron's chunks.
  function automatic int ref_sum(input int accw);
    int lim = (1 << (accw - 1)) - 1;
    int acc = 0;
    foreach (m_pos[i]) begin
      acc = acc + m_pos[i] - m_neg[i];
      if (acc > lim) acc = lim;
      if (acc < -lim) acc = -lim;
    end
    return acc;
  endfunction

  function automatic int ref_act(input int s, input int hi, input int lo);
    if (s >= hi) return 1;
    if (s <= lo) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    sb.delete();
    m_pos.delete();
    m_neg.delete();
    m_pending = 1'b0;
  endtask

  task automatic cycle(input bit v, input int p, input int n, input bit c, input bit r);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid   = v;
    in_pos_cnt = 5'(p);
    in_neg_cnt = 5'(n);
    clr        = c;
    out_ready  = r;
    thr_hi     = 8'(cur_hi);
    thr_lo     = 8'(cur_lo);
    @(negedge clk);
    check("in_ready_a", int'(in_ready_a), int'(!c && !m_pending));
    check("in_ready_b", int'(in_ready_b), int'(!c && !m_pending));
    check("out_valid_a", int'(out_valid_a), int'(m_pending));
    check("out_valid_b", int'(out_valid_b), int'(m_pending));
    #1;
    if (c) begin
      model_reset();
    end else if (m_pending) begin
      if (r) m_pending = 1'b0;
    end else if (v) begin
      m_pos.push_back(p);
      m_neg.push_back(n);
      if (m_pos.size() == NC) begin
        e.sum_a = ref_sum(8);
        e.sum_b = ref_sum(6);
        e.act_a = ref_act(e.sum_a, cur_hi, cur_lo);
        e.act_b = ref_act(e.sum_b, cur_hi, cur_lo);
        sb.push_back(e);
        m_pos.delete();
        m_neg.delete();
        m_pending = 1'b1;
      end
    end
  endtask

  // Monitor: compare every presented result against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !clr && out_valid_a) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          e = sb[0];
          check("out_sum_a", int'($signed(out_sum_a)), e.sum_a);
          check("out_act_a", int'(out_act_a), e.act_a);
          check("out_sum_b", int'($signed(out_sum_b)), e.sum_b);
          check("out_act_b", int'(out_act_b), e.act_b);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", int'(out_valid_a), 0);
    check("rst_in_ready", int'(in_ready_a), 1);
    check("rst_out_sum", int'(out_sum_a), 0);
    check("rst_out_act", int'(out_act_a), 0);

    // Basic +1 result
    cur_hi = 20; cur_lo = -20;
    repeat (4) cycle(1, 10, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);

    // -1 result with backpressure; offered beats must be refused while holding
    cur_hi = 5; cur_lo = -5;
    cycle(1, 0, 31, 0, 0);
    cycle(1, 1, 31, 0, 0);
    cycle(1, 2, 0, 0, 0);
    cycle(1, 3, 0, 0, 0);
    repeat (3) cycle(1, 7, 7, 0, 0);
    cycle(0, 0, 0, 0, 1);

    // Zero band, then overlapping thresholds
    cur_hi = 4; cur_lo = -4;
    cycle(1, 3, 0, 0, 1);
    repeat (3) cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cur_hi = 3; cur_lo = 3;
    cycle(1, 5, 2, 0, 1);
    repeat (3) cycle(1, 4, 4, 0, 1);
    cycle(0, 0, 0, 0, 1);

    // Saturation in both directions
    cur_hi = 20; cur_lo = -20;
    repeat (4) cycle(1, 31, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    repeat (4) cycle(1, 0, 31, 0, 1);
    cycle(0, 0, 0, 0, 1);

    // clr mid-evaluation, then a fresh neuron
    repeat (2) cycle(1, 9, 0, 0, 1);
    cycle(1, 9, 0, 1, 1);
    repeat (4) cycle(1, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);

    // clr colliding with the output handshake drops the result
    repeat (4) cycle(1, 2, 0, 0, 0);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) == 0) begin
        cur_hi = int'($urandom_range(62)) - 31;
        cur_lo = int'($urandom_range(62)) - 31;
      end
      cycle($urandom_range(3) != 0, int'($urandom_range(31)), int'($urandom_range(31)),
            $urandom_range(19) == 0, $urandom_range(9) < 7);
    end
    repeat (2) cycle(0, 0, 0, 0, 1);

    // Asynchronous reset while a result is held
    cur_hi = 10; cur_lo = -10;
    repeat (4) cycle(1, 5, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid_a", int'(out_valid_a), 0);
    check("async_rst_out_valid_b", int'(out_valid_b), 0);
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", int'(in_ready_a), 1);
    check("post_rst_out_sum_a", int'(out_sum_a), 0);
    check("post_rst_out_sum_b", int'(out_sum_b), 0);
    check("post_rst_out_act", int'(out_act_a), 0);
    repeat (4) cycle(1, 1, 0, 0, 1);
    repeat (2) cycle(0, 0, 0, 0, 1);

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tnn_neuron_accum.md
Name: tnn_neuron_accum

Overview:
- Ternary-neuron back end placed directly downstream of the popcount30 approximate popcount units.
- Each beat carries two 5-bit counts: the popcount of the +1-weight input chunk and the popcount of the −1-weight input chunk.
- The block accumulates (pos − neg) over NUM_CHUNKS beats, so one neuron can have up to NUM_CHUNKS×30 inputs per polarity.
- It then thresholds the signed sum into a ternary activation and presents it on a valid/ready output.

Parameters:
- CNT_W, 5: width of each incoming popcount; approximate units may emit values up to 31.
- NUM_CHUNKS, 4: beats per neuron evaluation; must be ≥1.
- ACC_W, 8: signed accumulator, threshold and out_sum width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort: flush the partial sum and drop any pending result.
- in_valid  in  1  a beat is offered.
- in_ready  out  1  the beat is accepted when in_valid && in_ready.
- in_pos_cnt  in  CNT_W  popcount of the +1-weight chunk.
- in_neg_cnt  in  CNT_W  popcount of the −1-weight chunk.
- thr_hi  in  ACC_W  signed upper threshold.
- thr_lo  in  ACC_W  signed lower threshold.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_act  out  2  ternary activation: 2'b01 = +1, 2'b11 = −1, 2'b00 = 0.
- out_sum  out  ACC_W  final signed (saturated) sum.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - Reset values: state = ACCUM, acc = 0, chunk_idx = 0, out_valid = 0, out_act = 2'b00, out_sum = 0.
- State ACCUM:
  - in_ready = !clr. This is combinational and depends on no other input.
  - On each accepted beat: acc <= sat(acc + zext(pos) − zext(neg)), and chunk_idx increments.
  - Saturation clamps to [−(2^(ACC_W−1)−1), +(2^(ACC_W−1)−1)]. The most-negative code is never produced.
- Last beat (chunk_idx == NUM_CHUNKS−1):
  - On the clock edge that accepts it, out_sum <= final saturated sum.
  - out_act <= threshold(final sum, thr_hi, thr_lo). The thresholds are sampled on this beat only.
  - acc <= 0, chunk_idx <= 0, out_valid <= 1, state <= RESULT.
  - Latency: the result is visible one cycle after the last beat is accepted.
- Threshold function:
  - sum ≥ thr_hi → +1.
  - Otherwise sum ≤ thr_lo → −1.
  - Otherwise 0.
  - +1 has priority when the thresholds overlap (thr_lo ≥ thr_hi).
- State RESULT:
  - in_ready = 0.
  - out_valid, out_act and out_sum stay stable until out_valid && out_ready.
  - That handshake returns the block to ACCUM with out_valid <= 0. No beat is accepted in the handshake cycle.
  - Throughput with out_ready held high: NUM_CHUNKS+1 cycles per neuron.
- clr, in any state, takes effect the next edge:
  - acc = 0, chunk_idx = 0, out_valid = 0, state = ACCUM.
  - out_act and out_sum keep their last values but are invalid.
  - clr together with in_valid: the beat is not accepted, because in_ready is low.
  - clr together with an output handshake: clr wins, with the same end state.
- NUM_CHUNKS = 1: every accepted beat produces a result.
- Input counts are treated as unsigned and used as-is. No clamping to 30 is applied, since the approximate counters may over-report.
- Asynchronous reset mid-evaluation: any partial sum is lost, and no result is emitted for that neuron.

Decomposition:
- Package tnn_pkg:
  - Ternary encoding constants TNN_POS = 2'b01, TNN_NEG = 2'b11, TNN_ZERO = 2'b00.
  - A function returning the saturation limit for ACC_W.
  - The state enum {ACCUM, RESULT}.
- Sub-module tnn_ternary_threshold: purely combinational (sum, thr_hi, thr_lo) → act. It is reused by the parallel neuron array.

Test Plan:
- Basic +1 result: default params, pos = 10,10,10,10, neg = 0,0,0,0, thr_hi = 20, thr_lo = −20 → out_valid one cycle after the 4th beat; out_sum = 40, out_act = 2'b01.
- −1 result with backpressure: pos = 0,1,2,3, neg = 31,31,0,0, thr_hi = 5, thr_lo = −5 → out_sum = −56, out_act = 2'b11. Hold out_ready = 0 for 3 cycles → outputs stable and in_ready = 0 throughout.
- Zero band and overlap priority:
  - Net sum 3 with thr_hi = 4, thr_lo = −4 → 2'b00.
  - Net sum 3 with thr_hi = 3, thr_lo = 3 → 2'b01 (+1 priority).
- Saturation: ACC_W = 6, NUM_CHUNKS = 4, pos = 31 ×4, neg = 0 → out_sum = 31. Mirrored with neg = 31 ×4, pos = 0 → out_sum = −31.
- clr mid-evaluation: assert clr with in_valid after 2 beats → beat not accepted. A following fresh 4 beats of pos = 1, neg = 0 → out_sum = 4.
- Async reset: drop rst_n while in RESULT with out_valid = 1 → out_valid = 0 immediately, without waiting for a clock edge. After release, in_ready = 1 and out_sum = 0.
